// File: rtl/sr_latch.sv
// Clocked SR latch with registered outputs, invalid (s=r=1) detection, sticky error and saturating entry counter.
// Optional input synchronizer: define SR_LATCH_INPUT_SYNC_EN (adds 2 cycles of input-to-output latency).
module sr_latch #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             err_clr,
  output logic             q,
  output logic             q_not,
  output logic             invalid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] invalid_cnt
);

  logic s_use;
  logic r_use;
  logic clr_use;

`ifdef SR_LATCH_INPUT_SYNC_EN
  logic [1:0] s_sync;
  logic [1:0] r_sync;
  logic [1:0] clr_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sync   <= '0;
      r_sync   <= '0;
      clr_sync <= '0;
    end else begin
      s_sync   <= {s_sync[0], s};
      r_sync   <= {r_sync[0], r};
      clr_sync <= {clr_sync[0], err_clr};
    end
  end

  assign s_use   = s_sync[1];
  assign r_use   = r_sync[1];
  assign clr_use = clr_sync[1];
`else
  assign s_use   = s;
  assign r_use   = r;
  assign clr_use = err_clr;
`endif

  logic             state;
  logic             both;
  logic             entry;
  logic             cnt_full;

  assign both     = s_use & r_use;
  // The registered invalid flag doubles as "previous sample was 1/1".
  assign entry    = both & ~invalid;
  assign cnt_full = &invalid_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= 1'b0;
      q       <= 1'b0;
      q_not   <= 1'b1;
      invalid <= 1'b0;
    end else begin
      unique case ({s_use, r_use})
        2'b10: begin
          state   <= 1'b1;
          q       <= 1'b1;
          q_not   <= 1'b0;
          invalid <= 1'b0;
        end
        2'b01: begin
          state   <= 1'b0;
          q       <= 1'b0;
          q_not   <= 1'b1;
          invalid <= 1'b0;
        end
        2'b11: begin
          q       <= 1'b0;
          q_not   <= 1'b0;
          invalid <= 1'b1;
        end
        default: begin
          q       <= state;
          q_not   <= ~state;
          invalid <= 1'b0;
        end
      endcase
    end
  end

  // A clear coinciding with an entry counts that entry after clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky  <= 1'b0;
      invalid_cnt <= '0;
    end else if (clr_use) begin
      err_sticky  <= both;
      invalid_cnt <= entry ? CNT_W'(1) : '0;
    end else begin
      err_sticky  <= err_sticky | both;
      if (entry && !cnt_full)
        invalid_cnt <= invalid_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_latch.sv
// Directed self-checking bench for sr_latch (CNT_W=4 so counter saturation is reachable).
module tb_sr_latch;

  localparam int unsigned CW = 4;
`ifdef SR_LATCH_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s;
  logic          r;
  logic          err_clr;
  logic          q;
  logic          q_not;
  logic          invalid;
  logic          err_sticky;
  logic [CW-1:0] invalid_cnt;

  int errors = 0;
  int checks = 0;

  sr_latch #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s),
    .r          (r),
    .err_clr    (err_clr),
    .q          (q),
    .q_not      (q_not),
    .invalid    (invalid),
    .err_sticky (err_sticky),
    .invalid_cnt(invalid_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, give err_clr a one-cycle pulse, and wait out the input latency.
  task automatic apply(input logic sv, input logic rv, input logic cv);
    s = sv; r = rv; err_clr = cv;
    tick();
    err_clr = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
  endtask

  task automatic chk_out(input string tag, input logic eq, input logic eqn,
                         input logic einv, input logic eerr, input logic [CW-1:0] ecnt);
    chk({tag, ".q"}, 16'(q), 16'(eq));
    chk({tag, ".q_not"}, 16'(q_not), 16'(eqn));
    chk({tag, ".invalid"}, 16'(invalid), 16'(einv));
    chk({tag, ".err"}, 16'(err_sticky), 16'(eerr));
    chk({tag, ".cnt"}, 16'(invalid_cnt), 16'(ecnt));
  endtask

  initial begin
    rst_n = 1'b0; s = 1'b0; r = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) apply(1'b0, 1'b0, 1'b0);
    chk_out("idle3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    apply(1'b0, 1'b1, 1'b0);
    chk_out("rst_req", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    apply(1'b1, 1'b0, 1'b0);
    chk_out("set_req", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < 5; i++) begin
      tick();
      s = 1'b0; r = 1'b0;
      chk("hold.q", 16'(q), 16'(1'b1));
      chk("hold.q_not", 16'(q_not), 16'(1'b0));
    end
    for (int i = 1; i < LAT; i++) tick();

    // Three cycles of s=r=1 count as a single entry.
    apply(1'b1, 1'b1, 1'b0);
    chk_out("inv_enter", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    tick(); tick();
    chk_out("inv_hold3", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    apply(1'b0, 1'b0, 1'b0);
    chk_out("inv_restore1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);

    apply(1'b1, 1'b1, 1'b0);
    chk_out("inv_enter2", 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
    apply(1'b0, 1'b1, 1'b0);
    chk_out("inv_to_reset", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    chk_out("inv_to_set", 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    apply(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    chk_out("inv_restore0", 1'b0, 1'b1, 1'b0, 1'b1, 4'd4);

    apply(1'b0, 1'b0, 1'b1);
    chk_out("clear", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    apply(1'b1, 1'b1, 1'b1);
    chk_out("clear_vs_entry", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    apply(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b1, 1'b0);
      apply(1'b0, 1'b0, 1'b0);
    end
    chk_out("saturate", 1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    apply(1'b0, 1'b0, 1'b1);
    chk_out("clear_sat", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset between edges while q=1.
    apply(1'b1, 1'b0, 1'b0);
    chk("pre_async.q", 16'(q), 16'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_q1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    s = 1'b0; r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0);
    chk_out("post_async", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset during the invalid condition.
    apply(1'b1, 1'b1, 1'b0);
    chk_out("pre_async_inv", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_inv", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    s = 1'b0; r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0);
    chk_out("post_async_inv", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_latch.md
SR_LATCH -- requirements
Module: sr_latch

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the invalid-event counter (legal 4..16).
REQ-002 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have s, input, 1, set request, level-sensitive.
REQ-005 SHALL have r, input, 1, reset request, level-sensitive.
REQ-006 SHALL have err_clr, input, 1, clears err_sticky and invalid_cnt.
REQ-007 SHALL have q, output, 1, latched state.
REQ-008 SHALL have q_not, output, 1, complementary output; 0 during the invalid condition.
REQ-009 SHALL have invalid, output, 1, high while the sampled s=r=1.
REQ-010 SHALL have err_sticky, output, 1, set on any invalid sample and held until cleared.
REQ-011 SHALL have invalid_cnt, output, CNT_W, saturating count of invalid-condition entries.

Function
REQ-012 SHALL sample s and r on each rising clk edge; outputs SHALL be registered (1-cycle latency, no combinational input-to-output path).
REQ-013 Sampled s=1, r=0: internal state SHALL become 1 (q=1, q_not=0).
REQ-014 Sampled s=0, r=1: internal state SHALL become 0 (q=0, q_not=1).
REQ-015 Sampled s=0, r=0: internal state and outputs SHALL hold.
REQ-016 Sampled s=1, r=1: q and q_not SHALL both be 0 and invalid SHALL be 1; internal state SHALL be left unchanged.
REQ-017 Leaving s=r=1 to s=r=0: q/q_not SHALL restore the internal state held before the invalid condition.
REQ-018 Leaving s=r=1 directly to s=1,r=0 or s=0,r=1: SHALL follow REQ-013/REQ-014 in that cycle.
REQ-019 Outside the invalid condition, q_not SHALL always equal the inverse of q.
REQ-020 invalid_cnt SHALL increment by 1 only on the cycle the invalid condition is entered (previous sample not 1/1); it SHALL saturate at all-ones without wrapping.
REQ-021 err_sticky SHALL be set in the same cycle invalid first asserts.
REQ-022 err_clr=1 SHALL clear err_sticky and invalid_cnt on the next edge; on a simultaneous entry into the invalid condition, the clear wins and then err_sticky=1 and invalid_cnt=1.

Reset
REQ-023 rst_n=0 SHALL immediately force internal state=0, q=0, q_not=1, invalid=0, err_sticky=0, invalid_cnt=0, and clear all pipeline/synchronizer flops.
REQ-024 Reset release SHALL take effect on the first rising clk edge with rst_n=1; no output shall be undefined after reset.
REQ-025 Reset asserted during an invalid condition SHALL override it (q_not=1).

Configuration
REQ-026 Macro SR_LATCH_INPUT_SYNC_EN defined: s, r and err_clr SHALL pass through a 2-flop synchronizer before use, giving 3-cycle input-to-output latency; the synchronizer flops SHALL reset to 0.
REQ-027 Macro SR_LATCH_INPUT_SYNC_EN undefined: no synchronizer; latency SHALL be 1 cycle per REQ-012.

Verification (latencies are for the macro undefined; add 2 cycles when it is defined)
REQ-028 Reset, then hold s=0,r=0 for 3 cycles -> q=0, q_not=1, invalid=0, invalid_cnt=0.
REQ-029 s=0,r=1 for 1 cycle -> q=0, q_not=1; then s=1,r=0 -> q=1, q_not=0 one cycle later.
REQ-030 After set, s=0,r=0 for 5 cycles -> q=1, q_not=0 held throughout.
REQ-031 s=1,r=1 for 3 cycles -> q=0, q_not=0, invalid=1, err_sticky=1, invalid_cnt=1 (not 3); then s=0,r=0 -> q=1, q_not=0 restored, err_sticky stays 1.
REQ-032 With CNT_W=4, 20 separate invalid entries -> invalid_cnt=15; err_clr pulse -> invalid_cnt=0, err_sticky=0.
REQ-033 rst_n low mid-clock while q=1 or s=r=1 -> q=0, q_not=1 immediately, before any clk edge.
